// File: rtl/pq_req_arb.sv
// pq_req_arb: round-robin arbiter sharing one priority queue among NREQ requesters.
// Define PQ_ARB_STATS_EN to build the saturating grant/stall statistics counters.
package pq_pkg;
    typedef struct packed {
        logic [15:0] key;
        logic [15:0] val;
    } kv_t;
endpackage

// state | meaning
// IDLE  | arbitrate among eligible requesters, register the winner
// ISSUE | drive one PQ strobe and the matching ack; capture pq_kvo for dequeues
// WAIT  | hold at least one cycle until the PQ drops pq_busy
module pq_req_arb
    import pq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    enq_req,
    input  logic [NREQ-1:0]    deq_req,
    input  kv_t  [NREQ-1:0]    req_kv,
    output logic [NREQ-1:0]    enq_ack,
    output logic [NREQ-1:0]    deq_ack,
    output logic [NREQ-1:0]    rsp_valid,
    output kv_t                rsp_kv,
    output kv_t                pq_kvi,
    output logic               pq_enq,
    output logic               pq_deq,
    input  logic               pq_full,
    input  logic               pq_busy,
    input  logic               pq_empty,
    input  kv_t                pq_kvo,
    output logic [15:0]        grant_cnt,
    output logic [15:0]        stall_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr, rr_ptr_d;
    logic [IW-1:0]   gnt_idx, gnt_idx_d;
    logic            gnt_deq, gnt_deq_d;
    kv_t             kvi_d, rsp_kv_d;
    logic            pq_enq_d, pq_deq_d;
    logic [NREQ-1:0] enq_ack_d, deq_ack_d, rsp_valid_d;

    logic [NREQ-1:0] enq_ok, deq_ok, elig;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     scan;

    // Scan from rr_ptr upward with wraparound; the first eligible index wins.
    always_comb begin
        enq_ok = enq_req & {NREQ{~pq_full}};
        deq_ok = deq_req & {NREQ{~pq_empty}};
        elig   = pq_busy ? '0 : (enq_ok | deq_ok);
        found  = 1'b0;
        pick   = '0;
        scan   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!found && elig[scan[IW-1:0]]) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_idx_d   = gnt_idx;
        gnt_deq_d   = gnt_deq;
        kvi_d       = pq_kvi;
        rsp_kv_d    = rsp_kv;
        pq_enq_d    = 1'b0;
        pq_deq_d    = 1'b0;
        enq_ack_d   = '0;
        deq_ack_d   = '0;
        rsp_valid_d = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d   = ISSUE;
                    gnt_idx_d = pick;
                    gnt_deq_d = deq_ok[pick];
                    kvi_d     = req_kv[pick];
                    rr_ptr_d  = (pick == IW'(NREQ-1)) ? '0 : pick + IW'(1);
                    pq_enq_d  = ~deq_ok[pick];
                    pq_deq_d  = deq_ok[pick];
                    if (deq_ok[pick])
                        deq_ack_d[pick] = 1'b1;
                    else
                        enq_ack_d[pick] = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                if (gnt_deq) begin
                    rsp_kv_d             = pq_kvo;
                    rsp_valid_d[gnt_idx] = 1'b1;
                end
            end
            WAIT: begin
                if (!pq_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            gnt_deq   <= 1'b0;
            pq_kvi    <= '0;
            rsp_kv    <= '0;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            enq_ack   <= '0;
            deq_ack   <= '0;
            rsp_valid <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            gnt_idx   <= gnt_idx_d;
            gnt_deq   <= gnt_deq_d;
            pq_kvi    <= kvi_d;
            rsp_kv    <= rsp_kv_d;
            pq_enq    <= pq_enq_d;
            pq_deq    <= pq_deq_d;
            enq_ack   <= enq_ack_d;
            deq_ack   <= deq_ack_d;
            rsp_valid <= rsp_valid_d;
        end
    end

`ifdef PQ_ARB_STATS_EN
    logic [15:0] grant_q, stall_q;
    logic        stall_now;

    assign stall_now = (state == IDLE) && (|(enq_req | deq_req)) && !found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            stall_q <= '0;
        end else begin
            if (state == ISSUE && grant_q != 16'hFFFF)
                grant_q <= grant_q + 16'd1;
            if (stall_now && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign grant_cnt = grant_q;
    assign stall_cnt = stall_q;
`else
    assign grant_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pq_req_arb.sv
// Scoreboard bench for pq_req_arb: a timeline reference model predicts every PQ
// strobe, ack and response; a monitor process compares them as the DUT presents them.
module tb_pq_req_arb;
    import pq_pkg::*;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] enq_req = '0;
    logic [NREQ-1:0] deq_req = '0;
    kv_t  [NREQ-1:0] req_kv = '0;
    logic [NREQ-1:0] enq_ack, deq_ack, rsp_valid;
    kv_t             rsp_kv, pq_kvi, pq_kvo = '0;
    logic            pq_enq, pq_deq;
    logic            pq_full = 1'b0, pq_busy = 1'b0, pq_empty = 1'b0;
    logic [15:0]     grant_cnt, stall_cnt;

    always #5 clk = ~clk;

    pq_req_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .enq_req(enq_req), .deq_req(deq_req), .req_kv(req_kv),
        .enq_ack(enq_ack), .deq_ack(deq_ack), .rsp_valid(rsp_valid), .rsp_kv(rsp_kv),
        .pq_kvi(pq_kvi), .pq_enq(pq_enq), .pq_deq(pq_deq),
        .pq_full(pq_full), .pq_busy(pq_busy), .pq_empty(pq_empty), .pq_kvo(pq_kvo),
        .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        int  cyc;
        int  idx;
        bit  deq;
        kv_t kv;
    } exp_t;

    exp_t op_q[$];
    exp_t rsp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: the arbiter is "blocked" from the grant until it may decide again.
    int  rr_m = 0;
    bit  issuing_m = 1'b0;
    bit  waiting_m = 1'b0;
    bit  iss_deq_m = 1'b0;
    int  iss_idx_m = 0;
    int  grant_m = 0;
    int  stall_m = 0;
    kv_t last_rsp = '0;
    bit  clr_v = 1'b0;
    bit  clr_deq = 1'b0;
    int  clr_idx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at window %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef PQ_ARB_STATS_EN
        return (v > 65535) ? 65535 : v;
`else
        return 0 * v;
`endif
    endfunction

    exp_t            mon_e;
    logic [NREQ-1:0] mon_oh;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("reset_strobes", 64'({pq_enq, pq_deq, enq_ack, deq_ack, rsp_valid}), 64'(0));
            chk("reset_kv", 64'({rsp_kv, pq_kvi}), 64'(0));
            chk("reset_cnt", 64'({grant_cnt, stall_cnt}), 64'(0));
        end else begin
            if (op_q.size() > 0 && op_q[0].cyc == cyc) begin
                mon_e  = op_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.idx] = 1'b1;
                chk("enq_ack", 64'(enq_ack), mon_e.deq ? 64'(0) : 64'(mon_oh));
                chk("deq_ack", 64'(deq_ack), mon_e.deq ? 64'(mon_oh) : 64'(0));
                chk("pq_strobes", 64'({pq_enq, pq_deq}), mon_e.deq ? 64'(1) : 64'(2));
                chk("pq_kvi", 64'(pq_kvi), 64'(mon_e.kv));
            end else begin
                chk("no_op", 64'({pq_enq, pq_deq, enq_ack, deq_ack}), 64'(0));
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                mon_e  = rsp_q.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.idx] = 1'b1;
                chk("rsp_valid", 64'(rsp_valid), 64'(mon_oh));
                chk("rsp_kv", 64'(rsp_kv), 64'(mon_e.kv));
            end else begin
                chk("no_rsp", 64'(rsp_valid), 64'(0));
                chk("rsp_kv_hold", 64'(rsp_kv), 64'(last_rsp));
            end
            chk("grant_cnt", 64'(grant_cnt), 64'(exp_cnt(grant_m)));
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt(stall_m)));
        end
    end

    task automatic model_step();
        int best, bestd, d;
        bit e_ok, d_ok;
        if (rst) begin
            op_q.delete();
            rsp_q.delete();
            rr_m = 0; issuing_m = 1'b0; waiting_m = 1'b0;
            grant_m = 0; stall_m = 0; last_rsp = '0; clr_v = 1'b0;
            return;
        end
        if (issuing_m) begin
            grant_m++;
            if (iss_deq_m) begin
                rsp_q.push_back('{cyc, iss_idx_m, 1'b1, pq_kvo});
                last_rsp = pq_kvo;
            end
            issuing_m = 1'b0;
            waiting_m = 1'b1;
        end else if (waiting_m) begin
            if (!pq_busy) waiting_m = 1'b0;
        end else begin
            best = -1;
            bestd = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                e_ok = enq_req[i] && !pq_full;
                d_ok = deq_req[i] && !pq_empty;
                d = (i - rr_m + NREQ) % NREQ;
                if (!pq_busy && (e_ok || d_ok) && d < bestd) begin
                    best = i;
                    bestd = d;
                end
            end
            if (best >= 0) begin
                d_ok = deq_req[best] && !pq_empty;
                op_q.push_back('{cyc, best, d_ok, req_kv[best]});
                rr_m = (best + 1) % NREQ;
                issuing_m = 1'b1;
                iss_deq_m = d_ok;
                iss_idx_m = best;
                clr_v = 1'b1; clr_deq = d_ok; clr_idx = best;
            end else if (|(enq_req | deq_req)) begin
                stall_m++;
            end
        end
    endtask

    // A window runs from one falling edge to the next; inputs change only here.
    task automatic wb();
        @(negedge clk);
        cyc++;
        if (clr_v) begin
            if (clr_deq) deq_req[clr_idx] = 1'b0;
            else         enq_req[clr_idx] = 1'b0;
            clr_v = 1'b0;
        end
    endtask

    task automatic we();
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            wb();
            we();
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (!enq_req[i] && $urandom_range(0, 3) == 0) begin
                req_kv[i] = kv_t'($urandom);
                enq_req[i] = 1'b1;
            end
            if (!deq_req[i] && $urandom_range(0, 4) == 0) deq_req[i] = 1'b1;
            if ($urandom_range(0, 40) == 0) enq_req[i] = 1'b0;
            if ($urandom_range(0, 40) == 0) deq_req[i] = 1'b0;
        end
        pq_full  = ($urandom_range(0, 5) == 0);
        pq_empty = ($urandom_range(0, 5) == 0);
        pq_busy  = ($urandom_range(0, 2) == 0);
        pq_kvo   = kv_t'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        wb(); rst = 1'b0; we();

        // single enqueue
        wb(); req_kv[0] = '{16'h0005, 16'h5555}; enq_req[0] = 1'b1; we();
        idle(6);

        // dequeue path
        wb(); pq_kvo = '{16'h0009, 16'h9999}; deq_req[2] = 1'b1; we();
        idle(6);

        // fairness from reset with every requester always asking
        wb(); rst = 1'b1; we();
        wb(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) req_kv[i] = '{16'(i), 16'hA000 + 16'(i)};
        enq_req = '1; we();
        repeat (22) begin
            wb(); enq_req = '1; we();
        end
        wb(); enq_req = '0; we();
        idle(5);

        // full blocks enqueues, empty blocks dequeues, both high blocks everything
        wb(); pq_full = 1'b1; req_kv[1] = '{16'h0011, 16'h1111}; enq_req[1] = 1'b1; deq_req[3] = 1'b1; we();
        idle(6);
        wb(); pq_full = 1'b0; enq_req[1] = 1'b0; pq_empty = 1'b1; deq_req[0] = 1'b1; deq_req[2] = 1'b1; we();
        idle(5);
        wb(); pq_full = 1'b1; we();
        idle(3);
        wb(); pq_full = 1'b0; pq_empty = 1'b0; we();
        idle(10);

        // busy held five cycles after an issue
        wb(); req_kv[1] = '{16'h0021, 16'h2121}; enq_req[1] = 1'b1;
        req_kv[2] = '{16'h0022, 16'h2222}; enq_req[2] = 1'b1; we();
        wb(); we();
        repeat (5) begin
            wb(); pq_busy = 1'b1; we();
        end
        wb(); pq_busy = 1'b0; we();
        idle(8);

        // reset while waiting after a dequeue
        wb(); pq_kvo = '{16'h0009, 16'h0999}; deq_req[3] = 1'b1; we();
        wb(); pq_busy = 1'b1; we();
        wb(); we();
        wb(); rst = 1'b1; deq_req = '0;
        req_kv[1] = '{16'h0031, 16'h3131}; req_kv[3] = '{16'h0033, 16'h3333};
        enq_req[1] = 1'b1; enq_req[3] = 1'b1; we();
        wb(); we();
        wb(); rst = 1'b0; pq_busy = 1'b0; we();
        idle(10);

        // randomized traffic with occasional mid-flight resets
        for (int n = 0; n < 3000; n++) begin
            wb();
            rand_inputs();
            rst = (n % 500 == 250);
            we();
        end

        wb(); rst = 1'b0; enq_req = '0; deq_req = '0; pq_busy = 1'b0; pq_full = 1'b0; pq_empty = 1'b0; we();
        idle(10);
        chk("op_queue_drained", 64'(op_q.size()), 64'(0));
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pq_req_arb.md
PQ_REQ_ARB -- requirements
Module: pq_req_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one priority queue (2..8).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 enq_req  input  NREQ  per-requester enqueue request, level, held until enq_ack.
REQ-005 deq_req  input  NREQ  per-requester dequeue request, level, held until deq_ack.
REQ-006 req_kv  input  NREQ x kv_t  per-requester key/value for enqueue (kv_t from pq_pkg), stable while enq_req high.
REQ-007 enq_ack  output  NREQ  one-cycle pulse, enqueue issued to PQ.
REQ-008 deq_ack  output  NREQ  one-cycle pulse, dequeue issued to PQ.
REQ-009 rsp_valid  output  NREQ  one-cycle pulse, rsp_kv holds dequeued entry for that requester.
REQ-010 rsp_kv  output  kv_t  dequeued key/value, shared by all requesters.
REQ-011 pq_kvi  output  kv_t  key/value to PQ kvi.
REQ-012 pq_enq, pq_deq  output  1 each  PQ enq/deq strobes.
REQ-013 pq_full, pq_busy, pq_empty  input  1 each  PQ status.
REQ-014 pq_kvo  input  kv_t  PQ head entry.
REQ-015 grant_cnt, stall_cnt  output  16 each  statistics (see Configuration).

Function
REQ-016 FSM states IDLE, ISSUE, WAIT; all outputs registered.
REQ-017 Eligibility in IDLE: enq eligible if enq_req[i] && !pq_full; deq eligible if deq_req[i] && !pq_empty; none eligible while pq_busy high.
REQ-018 Arbitration: round-robin over requesters from pointer rr_ptr; requester eligible if either op eligible; within one requester deq beats enq.
REQ-019 IDLE with grant at cycle t: register granted index, op, req_kv; next state ISSUE; rr_ptr <= (granted+1) mod NREQ.
REQ-020 ISSUE (cycle t+1): exactly one of pq_enq/pq_deq high for one cycle, pq_kvi = registered req_kv; matching enq_ack/deq_ack pulse for granted requester; for deq, rsp_kv <= pq_kvo; next state WAIT.
REQ-021 Deq response: rsp_valid[granted] pulses at t+2 with rsp_kv stable until next deq.
REQ-022 WAIT: minimum one cycle; return to IDLE first cycle pq_busy low; earliest next grant decision t+3, earliest next issue t+4.
REQ-023 At most one PQ operation in flight; pq_enq and pq_deq never high together; never high outside ISSUE.
REQ-024 Requests withdrawn before grant are ignored; no ack generated.
REQ-025 pq_full and pq_empty both high (impossible PQ) -> nothing eligible, stay IDLE.
REQ-026 No requests: stay IDLE, rr_ptr unchanged.

Reset
REQ-027 rst high: immediately state IDLE, rr_ptr 0, pq_enq/pq_deq/enq_ack/deq_ack/rsp_valid 0, pq_kvi and rsp_kv all-zero, counters 0.
REQ-028 Reset mid-ISSUE or mid-WAIT aborts the operation; no ack or rsp_valid after reset release; first grant earliest first edge after release.

Configuration
REQ-029 Macro PQ_ARB_STATS_EN defined: grant_cnt increments per ISSUE cycle; stall_cnt increments each IDLE cycle with any request pending but no grant; both saturate at 16'hFFFF.
REQ-030 PQ_ARB_STATS_EN undefined: counter logic absent, grant_cnt and stall_cnt tied to 0; all other behaviour identical.

Verification
REQ-031 Single enq: enq_req[0]=1, req_kv=K5, PQ idle -> pq_enq and enq_ack[0] at t+1, pq_kvi=K5, IDLE at t+3 if busy low.
REQ-032 Fairness: all four requesters hold enq_req from reset, PQ never full -> grants 0,1,2,3,0 in order.
REQ-033 Deq path: pq_kvo=K9, deq_req[2]=1 -> pq_deq and deq_ack[2] at t+1, rsp_valid[2] at t+2, rsp_kv=K9.
REQ-034 Full/empty: pq_full=1 with enq_req[1], deq_req[3] -> only requester 3 granted; pq_empty=1 with only deq requests -> no grant, stall_cnt increments (stats build).
REQ-035 Busy hold: pq_busy high 5 cycles after issue -> FSM in WAIT 5 cycles, no strobes, next issue only after busy falls.
REQ-036 Reset in WAIT after deq issue -> no rsp_valid, outputs zero, rr_ptr 0, next grant to lowest eligible index.
